sim_stream_master: RTL and testbench

SIM_STREAM_MASTER -- requirements
Module: sim_stream_master

---
 rtl/sim_stream_master_pkg.sv | 10 +
 rtl/sim_stream_master.sv | 131 +++++++++++++
 tb/tb_sim_stream_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sim_stream_master_pkg.sv
// Shared types for the simulation stream master and its users.
//   byte_q_t        : one packet as a queue of bytes, byte 0 first
//   DEFAULT_DATA_W  : default stream data width in bits
package sim_stream_master_pkg;

    typedef logic [7:0] byte_q_t [$];

    localparam int unsigned DEFAULT_DATA_W = 32;

endpackage

// File: rtl/sim_stream_master.sv
// Simulation-only packet stream master. Packets are queued by the write /
// write_err tasks in zero time and played out as a valid/ready beat stream.
// Ports:
//   clk_i           stream clock
//   rst_i           synchronous active-high reset, flushes all queued packets
//   m_axis_valid_o  beat valid
//   m_axis_data_o   beat data, stream byte k on lane k%BYTES
//   m_axis_keep_o   byte enables, contiguous from lane 0
//   m_axis_vldb_o   valid bytes in the beat minus one
//   m_axis_sop_o    first beat of a packet
//   m_axis_eop_o    last beat of a packet
//   m_axis_err_o    error flag, only on the eop beat of a write_err packet
//   m_axis_ready_i  sink ready
module sim_stream_master
    import sim_stream_master_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    output logic                              m_axis_valid_o,
    output logic [DATA_W-1:0]                 m_axis_data_o,
    output logic [DATA_W/8-1:0]               m_axis_keep_o,
    output logic [$clog2(DATA_W/8)-1:0]       m_axis_vldb_o,
    output logic                              m_axis_sop_o,
    output logic                              m_axis_eop_o,
    output logic                              m_axis_err_o,
    input  logic                              m_axis_ready_i
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned VW    = $clog2(BYTES);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [BYTES-1:0]  keep;
        logic [VW-1:0]     vldb;
        logic              sop;
        logic              eop;
        logic              err;
    } beat_t;

    // Packet FIFO. Entries are never popped; rd_idx marks the next packet to
    // send, so the clocked stage only ever reads the queues.
    byte_q_t pkt_q [$];
    logic    err_q [$];

    beat_t beat_r;
    int    rd_idx;
    int    cur_idx;
    int    off;

    // Append one packet; dropped while in reset or when empty.
    task automatic enqueue(input byte_q_t pkt, input logic is_err);
        if (rst_i) begin
            return;
        end
        if (pkt.size() == 0) begin
            $display("sim_stream_master: warning: zero-length packet discarded at %0t", $time);
            return;
        end
        pkt_q.push_back(pkt);
        err_q.push_back(is_err);
    endtask

    task automatic write(input byte_q_t pkt);
        enqueue(pkt, 1'b0);
    endtask

    task automatic write_err(input byte_q_t pkt);
        enqueue(pkt, 1'b1);
    endtask

    // Build the beat starting at byte offset 'start' of packet 'idx'.
    function automatic beat_t make_beat(input int idx, input int start);
        beat_t b;
        int    len;
        int    rem;
        b   = '0;
        len = pkt_q[idx].size();
        rem = len - start;
        if (rem > int'(BYTES)) begin
            rem = int'(BYTES);
        end
        b.valid = 1'b1;
        for (int n = 0; n < int'(BYTES); n++) begin
            if (n < rem) begin
                b.data[8*n +: 8] = pkt_q[idx][start + n];
                b.keep[n]        = 1'b1;
            end
        end
        b.vldb = VW'(rem - 1);
        b.sop  = (start == 0);
        b.eop  = (start + int'(BYTES) >= len);
        b.err  = b.eop && err_q[idx];
        return b;
    endfunction

    // Beat register: load a new beat whenever the output slot is empty or
    // the presented beat transfers this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_r  <= '0;
            rd_idx  <= pkt_q.size();
            cur_idx <= 0;
            off     <= 0;
        end else if (!beat_r.valid || m_axis_ready_i) begin
            if (beat_r.valid && !beat_r.eop) begin
                beat_r <= make_beat(cur_idx, off + int'(BYTES));
                off    <= off + int'(BYTES);
            end else if (rd_idx < pkt_q.size()) begin
                beat_r  <= make_beat(rd_idx, 0);
                cur_idx <= rd_idx;
                off     <= 0;
                rd_idx  <= rd_idx + 1;
            end else begin
                beat_r <= '0;
            end
        end
    end

    assign m_axis_valid_o = beat_r.valid;
    assign m_axis_data_o  = beat_r.data;
    assign m_axis_keep_o  = beat_r.keep;
    assign m_axis_vldb_o  = beat_r.vldb;
    assign m_axis_sop_o   = beat_r.sop;
    assign m_axis_eop_o   = beat_r.eop;
    assign m_axis_err_o   = beat_r.err;

endmodule

// File: tb/tb_sim_stream_master.sv
// Self-checking bench for sim_stream_master: directed scenarios plus a
// randomized packet/backpressure run checked against a packet-level model.
module tb_sim_stream_master;
    import sim_stream_master_pkg::*;

    localparam int DW = 32;
    localparam int NB = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic [1:0]    vldb;
        logic          sop;
        logic          eop;
        logic          err;
        longint        cyc;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          ready = 1'b1;
    logic          valid;
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic [1:0]    vldb;
    logic          sop;
    logic          eop;
    logic          err;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;

    beat_t exp_q [$];
    beat_t log_q [$];

    sim_stream_master #(.DATA_W(DW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .m_axis_valid_o (valid),
        .m_axis_data_o  (data),
        .m_axis_keep_o  (keep),
        .m_axis_vldb_o  (vldb),
        .m_axis_sop_o   (sop),
        .m_axis_eop_o   (eop),
        .m_axis_err_o   (err),
        .m_axis_ready_i (ready)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pack(input beat_t b);
        return {23'd0, b.data, b.keep, b.vldb, b.sop, b.eop, b.err};
    endfunction

    // Packet-level model: split the byte list into BYTES-wide beats.
    task automatic model_add(input byte_q_t q, input bit e);
        int len;
        int nbeats;
        len    = q.size();
        nbeats = (len + NB - 1) / NB;
        for (int b = 0; b < nbeats; b++) begin
            beat_t x;
            int    cnt;
            cnt    = (b == nbeats - 1) ? len - b * NB : NB;
            x.data = '0;
            for (int n = 0; n < cnt; n++) begin
                x.data[8*n +: 8] = q[b * NB + n];
            end
            x.keep = NB'((1 << cnt) - 1);
            x.vldb = 2'(cnt - 1);
            x.sop  = (b == 0);
            x.eop  = (b == nbeats - 1);
            x.err  = e && (b == nbeats - 1);
            x.cyc  = 0;
            exp_q.push_back(x);
        end
    endtask

    task automatic send(input byte_q_t q, input bit e);
        if (e) dut.write_err(q);
        else   dut.write(q);
        if (!rst_i && q.size() > 0) model_add(q, e);
    endtask

    task automatic rand_pkt(input int len, output byte_q_t q);
        q = {};
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_log(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc && log_q.size() < n; i++) tick(1);
        check("wait_beats", 64'(log_q.size() >= n), 64'd1);
    endtask

    // Monitor: transfers vs model, hold under backpressure, no gaps, idle zeros.
    beat_t prev;
    bit    prev_stall  = 1'b0;
    bit    expect_next = 1'b0;
    always @(negedge clk_i) begin
        beat_t cur;
        cyc++;
        cur.data = data; cur.keep = keep; cur.vldb = vldb;
        cur.sop = sop; cur.eop = eop; cur.err = err; cur.cyc = cyc;
        if (rst_i) begin
            prev_stall  = 1'b0;
            expect_next = 1'b0;
        end else begin
            if (prev_stall) check("hold", pack(cur), pack(prev));
            if (expect_next) check("no_gap_valid", 64'(valid), 64'd1);
            expect_next = 1'b0;
            if (!valid) begin
                check("idle_zero", pack(cur), 64'd0);
                if (exp_q.size() != 0) expect_next = 1'b1;
            end else if (ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    check("beat", pack(cur), pack(exp_q.pop_front()));
                end
                log_q.push_back(cur);
                if (exp_q.size() != 0) expect_next = 1'b1;
            end
            prev_stall = valid && !ready;
            prev       = cur;
        end
    end

    initial begin
        byte_q_t q;
        byte_q_t q2;
        bit      any_eop;
        int      left;

        tick(3);
        rst_i = 1'b0;
        check("reset_state", {55'd0, valid, sop, eop, err, keep}, 64'd0);
        check("reset_data", 64'(data), 64'd0);

        // 60-byte packet, ready held high
        log_q.delete();
        rand_pkt(54, q2);
        q = {8'h84, 8'h5b, 8'h12, 8'h62, 8'h5b, 8'h9d};
        foreach (q2[i]) q.push_back(q2[i]);
        send(q, 1'b0);
        wait_log(15, 100);
        tick(3);
        check("p60_beats", 64'(log_q.size()), 64'd15);
        check("p60_b0_data", 64'(log_q[0].data), 64'h62125b84);
        check("p60_b0_sop", 64'(log_q[0].sop), 64'd1);
        check("p60_b14_last", {log_q[14].eop, log_q[14].keep, log_q[14].vldb, log_q[14].err},
              {1'b1, 4'hF, 2'd3, 1'b0});

        // 61-byte packet: one-byte tail beat
        log_q.delete();
        rand_pkt(61, q);
        send(q, 1'b0);
        wait_log(16, 100);
        tick(3);
        check("p61_beats", 64'(log_q.size()), 64'd16);
        check("p61_tail_keep", 64'(log_q[15].keep), 64'h1);
        check("p61_tail_vldb", 64'(log_q[15].vldb), 64'd0);
        check("p61_tail_upper", 64'(log_q[15].data[31:8]), 64'd0);

        // backpressure on beat 5
        log_q.delete();
        rand_pkt(40, q);
        send(q, 1'b0);
        wait_log(5, 100);
        ready = 1'b0;
        tick(3);
        ready = 1'b1;
        wait_log(10, 100);
        check("stall_b5_gap", 64'(log_q[5].cyc - log_q[4].cyc), 64'd4);
        check("stall_b6_next", 64'(log_q[6].cyc - log_q[5].cyc), 64'd1);
        tick(3);

        // back-to-back packets, second with error
        log_q.delete();
        rand_pkt(8, q);
        rand_pkt(5, q2);
        send(q, 1'b0);
        send(q2, 1'b1);
        wait_log(4, 100);
        tick(3);
        check("b2b_beats", 64'(log_q.size()), 64'd4);
        check("b2b_sop_gap", 64'(log_q[2].cyc - log_q[1].cyc), 64'd1);
        check("b2b_sop", 64'(log_q[2].sop), 64'd1);
        check("b2b_err_eop", {log_q[3].eop, log_q[3].err, log_q[3].keep}, {1'b1, 1'b1, 4'h1});
        check("b2b_p1_noerr", 64'(log_q[1].err), 64'd0);

        // empty packet is dropped
        q = {};
        send(q, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("empty_no_valid", 64'(valid), 64'd0);
        end

        // reset mid-packet with a second packet queued
        log_q.delete();
        rand_pkt(40, q);
        rand_pkt(20, q2);
        send(q, 1'b0);
        send(q2, 1'b0);
        wait_log(3, 100);
        rst_i = 1'b1;
        exp_q.delete();
        send(q2, 1'b0);
        tick(1);
        rst_i = 1'b0;
        check("rst_outputs", {55'd0, valid, sop, eop, err, keep}, 64'd0);
        tick(10);
        check("rst_beats", 64'(log_q.size()), 64'd3);
        any_eop = 1'b0;
        foreach (log_q[i]) any_eop |= log_q[i].eop;
        check("rst_no_eop", 64'(any_eop), 64'd0);
        check("rst_idle", 64'(valid), 64'd0);

        // randomized traffic and backpressure
        log_q.delete();
        left = 40;
        for (int c = 0; c < 4000 && left > 0; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                rand_pkt($urandom_range(0, 40), q);
                send(q, 1'($urandom_range(0, 1)));
                left--;
            end
            tick(1);
        end
        ready = 1'b1;
        for (int c = 0; c < 3000 && (exp_q.size() != 0 || valid); c++) tick(1);
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        tick(3);
        check("rand_idle", 64'(valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
